// File: rtl/instrumented_adder_ctrl_pkg.sv
// Shared definitions for the instrumented adder measurement sequencer:
// register offsets, CTRL bit positions, FSM encoding and a byte-select merge helper.
package instrumented_adder_ctrl_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_A      = 8'h08;
  localparam logic [7:0] REG_B      = 8'h0C;
  localparam logic [7:0] REG_WINDOW = 8'h10;
  localparam logic [7:0] REG_EDGES  = 8'h14;
  localparam logic [7:0] REG_SUM    = 8'h18;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] applySel(input logic [31:0] oldVal,
                                           input logic [31:0] newVal,
                                           input logic [3:0]  sel);
    logic [31:0] merged;
    merged = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[i*8 +: 8] = newVal[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/instrumented_adder_ctrl_ring_edge_sync.sv
// Brings the free-running oscillator tap into the Wishbone clock domain and
// emits a one-cycle pulse for every rising edge seen after synchronisation.
module ring_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ring,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_ring;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/instrumented_adder_ctrl.sv
// Wishbone-controlled measurement sequencer: holds adder operands, opens a
// ring-oscillator window of WINDOW cycles, counts tap edges and captures the sum.
module instrumented_adder_ctrl
  import instrumented_adder_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 8,
  parameter int          CNT_W     = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             ring_i,
  input  logic [WIDTH:0]   sum_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             ring_en_o,
  output logic             busy_o
);

  state_t             r_state;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_window;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_edges;
  logic [WIDTH:0]     r_sum;
  logic               r_ringEn;
  logic               r_busy;

  logic               w_inPage;
  logic               w_req;
  logic               w_wr;
  logic [7:0]         w_off;
  logic               w_cfgWr;
  logic               w_start;
  logic               w_clr;
  logic               w_rise;
  logic [31:0]        w_rdata;

  // A request held across the ack cycle must not be acked twice.
  assign w_inPage = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req    = wbs_stb_i & wbs_cyc_i & w_inPage & ~r_ack;
  assign w_wr     = w_req & wbs_we_i;
  assign w_off    = wbs_adr_i[7:0];
  assign w_cfgWr  = w_wr & (r_state != ST_RUN);
  assign w_start  = w_cfgWr & (w_off == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
  assign w_clr    = w_cfgWr & (w_off == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];

  ring_edge_sync u_ringSync (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_ring (ring_i),
    .o_rise (w_rise)
  );

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_STATUS: w_rdata = {30'd0, (r_state == ST_DONE), (r_state == ST_RUN)};
      REG_A:      w_rdata = 32'(r_a);
      REG_B:      w_rdata = 32'(r_b);
      REG_WINDOW: w_rdata = 32'(r_window);
      REG_EDGES:  w_rdata = 32'(r_edges);
      REG_SUM:    w_rdata = 32'(r_sum);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_window <= '0;
    end else if (w_cfgWr) begin
      case (w_off)
        REG_A:      r_a      <= WIDTH'(applySel(32'(r_a), wbs_dat_i, wbs_sel_i));
        REG_B:      r_b      <= WIDTH'(applySel(32'(r_b), wbs_dat_i, wbs_sel_i));
        REG_WINDOW: r_window <= CNT_W'(applySel(32'(r_window), wbs_dat_i, wbs_sel_i));
        default:    ;
      endcase
    end
  end

  // START from IDLE or DONE reloads; a zero window skips RUN entirely.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_edges  <= '0;
      r_sum    <= '0;
      r_ringEn <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_edges <= '0;
            if (r_window != '0) begin
              r_state  <= ST_RUN;
              r_cnt    <= r_window;
              r_ringEn <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_sum   <= sum_i;
            end
          end else if (w_clr && r_state == ST_DONE) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_rise && !(&r_edges)) r_edges <= r_edges + CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= ST_DONE;
            r_sum    <= sum_i;
            r_ringEn <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ringEn <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign a_o       = r_a;
  assign b_o       = r_b;
  assign ring_en_o = r_ringEn;
  assign busy_o    = r_busy;

endmodule

// File: doc/instrumented_adder_ctrl.md
# instrumented_adder_ctrl

Wishbone-controlled measurement sequencer for the instrumented adder; it sits inside the project wrapper, directly downstream of the wrapper's Wishbone and tristate layer. It holds the adder operands and enables the adder's ring-oscillator path for a programmable window of `wb_clk_i` cycles. During that window it counts rising edges of the oscillator tap and then captures the adder sum. All outputs feed the wrapper's buffered (`buf_*`) nets or the adder core.

## Interface
Parameters:
- `BASE_ADDR`, `32'h3000_0000`: Wishbone base; bits [31:8] are decoded.
- `WIDTH`, `8`: adder operand width, 1..16.
- `CNT_W`, `32`: width of the window counter and the edge counter, 8..32.

Ports (one clock; reset is asynchronous and active-high):
- `wb_clk_i`  in  1  the only clock
- `wb_rst_i`  in  1  asynchronous, active-high reset
- `wbs_stb_i`  in  1  Wishbone strobe
- `wbs_cyc_i`  in  1  Wishbone cycle
- `wbs_we_i`  in  1  write enable
- `wbs_sel_i`  in  4  byte selects
- `wbs_dat_i`  in  32  write data
- `wbs_adr_i`  in  32  byte address
- `wbs_ack_o`  out  1  acknowledge
- `wbs_dat_o`  out  32  read data, valid while ack is high
- `ring_i`  in  1  oscillator tap, asynchronous to `wb_clk_i`
- `sum_i`  in  WIDTH+1  adder result
- `a_o`, `b_o`  out  WIDTH  operands to the adder
- `ring_en_o`  out  1  oscillator enable
- `busy_o`  out  1  high in RUN

## Operation
Register map (offset from BASE; unused bits read 0):
- 0x00 CTRL, write-only, reads 0.
  - bit0 START.
  - bit1 CLR.
- 0x04 STATUS, read-only.
  - bit0 busy.
  - bit1 done.
- 0x08 A, R/W, [WIDTH-1:0].
- 0x0C B, R/W, [WIDTH-1:0].
- 0x10 WINDOW, R/W, [CNT_W-1:0].
- 0x14 EDGES, read-only, [CNT_W-1:0].
- 0x18 SUM, read-only, [WIDTH:0].
- Any other offset inside the 256-byte page: acked, reads 0, writes ignored.
- Addresses outside the page: no ack.
- Writes honour `wbs_sel_i` per byte.

FSM states:
- IDLE
  - START=1 with WINDOW≠0 → RUN: load the window counter from WINDOW and clear EDGES.
  - START=1 with WINDOW=0 → DONE: EDGES=0, SUM captured.
- RUN
  - `ring_en_o`=1 and `busy_o`=1.
  - The window counter decrements every cycle.
  - Each detected rising edge of the synchronised `ring_i` increments EDGES. EDGES saturates at all-ones.
  - On the cycle the counter equals 1: capture `sum_i` into SUM → DONE.
- DONE
  - done=1.
  - START → RUN, reloading as from IDLE.
  - CLR → IDLE; EDGES and SUM are retained.
- If START and CLR are written together, START wins.
- In RUN, writes to CTRL, A, B and WINDOW are ignored but still acked. Reads are always serviced.

`ring_i` path: a 2-flop synchroniser, then a registered previous-value edge detector. An edge is counted only when the detector fires while in RUN.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `a_o`=`b_o`=0.
  - `ring_en_o`=0, `busy_o`=0.
  - State IDLE; all registers 0; synchroniser flops 0.
- Reset asserted mid-RUN drops `ring_en_o` asynchronously.
- Wishbone handshake:
  - `wbs_ack_o` rises one cycle after a matching `stb&cyc` is sampled and stays high for exactly one cycle.
  - A request sampled while ack is high is not acked again; the master holds `stb` for a new access.
  - Write side effects, including the START transition, take effect on the same edge that raises ack.
- RUN lasts exactly WINDOW cycles:
  - `ring_en_o` is high for WINDOW cycles, starting the cycle after the START write's ack edge.
  - done is visible on the first DONE cycle.
- Edge latency: a `ring_i` rise is counted 3 to 4 `wb_clk_i` edges later. Rises within the final 3 cycles of the window may be missed; this is by design.
- `a_o`/`b_o` update the cycle after the write ack edge.

## Structure
- Shared package/header holds:
  - register offsets (`REG_CTRL`…`REG_SUM`);
  - CTRL bit indices;
  - the FSM state encoding: IDLE=0, RUN=1, DONE=2.
- One sub-module, `ring_edge_sync`: 2-flop synchroniser plus rising-edge pulse output, with asynchronous reset.
- The top holds the Wishbone decode, the register bank, the FSM and the counters.

## Test plan
- Reset, then read every offset 0x00–0x18 → all read 0. Each ack is exactly one cycle wide.
- Write A=0x5A, B=0x33 (sel=4'b0001) and read back → 0x5A, 0x33, and `a_o`/`b_o` match.
- WINDOW=20, START, `ring_i` toggling with a period of 8 clocks:
  - `ring_en_o` high for exactly 20 cycles;
  - STATUS=2 afterwards;
  - EDGES in 2..3;
  - SUM equals `sum_i` at the final RUN cycle.
- WINDOW=0, START → STATUS=2 on the next read, EDGES=0, `ring_en_o` never high.
- During RUN, write A=0xFF and START → A unchanged, the run completes on schedule; then CLR → STATUS=0.
- Assert `wb_rst_i` mid-RUN → `ring_en_o`=0 immediately, STATUS=0 after release; an access to BASE+0x100 is never acked.
